// File: rtl/temp_disp_pkg.sv
// Shared types and constants for the two-digit temperature display scanner.
package temp_disp_pkg;

  typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

  localparam int unsigned CLAMP_MAX = 99;

  // Active-low segment patterns ordered {A,B,C,D,E,F,G}.
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module seg7_encode
  import temp_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/temp_display_scanner.sv
// Clamp, double-dabble convert and multiplex a temperature sample onto a two-digit display.
// Optional macro LEADING_ZERO_BLANK_EN hides the tens digit while it is zero.
module temp_display_scanner
  import temp_disp_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] temp_in,
  input  logic              temp_valid,
  output logic              busy,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              D,
  output logic              E,
  output logic              F,
  output logic              G,
  output logic              dig_ones_n,
  output logic              dig_tens_n
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam int unsigned RefW = $clog2(REFRESH_DIV);

  state_e              state_q, state_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [7:0]          bcd_q, bcd_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic [3:0]          tens_q, tens_d, ones_q, ones_d;
  logic [RefW-1:0]     refresh_q, refresh_d;
  logic                sel_tens_q, sel_tens_d;
  logic [6:0]          seg_q, seg_d;
  logic                ones_n_q, ones_n_d, tens_n_q, tens_n_d;

  logic [DATA_W-1:0]   clamped;
  logic [7:0]          bcd_adj;
  logic [DATA_W+7:0]   shift_v;
  logic [3:0]          digit_mux;
  logic [6:0]          enc_seg;
  logic                blank, tens_hidden, active;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    clamped     = (temp_in > DATA_W'(CLAMP_MAX)) ? DATA_W'(CLAMP_MAX) : temp_in;
    bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    shift_v     = {bcd_adj, bin_q} << 1;

    unique case (state_q)
      StIdle: begin
        if (temp_valid) begin
          bin_d     = clamped;
          bcd_d     = '0;
          bit_cnt_d = '0;
          state_d   = StConv;
        end
      end
      StConv: begin
        bcd_d     = shift_v[DATA_W+7:DATA_W];
        bin_d     = shift_v[DATA_W-1:0];
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CntW'(DATA_W - 1)) state_d = StLoad;
      end
      StLoad: begin
        tens_d = bcd_q[7:4];
        ones_d = bcd_q[3:0];
        if (pend_q) begin
          bin_d     = pend_data_q;
          bcd_d     = '0;
          bit_cnt_d = '0;
          pend_d    = 1'b0;
          state_d   = StConv;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Placed last so a strobe coinciding with the recapture refills pending.
    if (state_q != StIdle && temp_valid) begin
      pend_d      = 1'b1;
      pend_data_d = clamped;
    end
  end

  seg7_encode u_seg7_encode (
    .bcd_i (digit_mux),
    .seg_o (enc_seg)
  );

  always_comb begin
    refresh_d  = refresh_q + 1'b1;
    sel_tens_d = sel_tens_q;
    if (refresh_q == RefW'(REFRESH_DIV - 1)) begin
      refresh_d  = '0;
      sel_tens_d = ~sel_tens_q;
    end
    digit_mux = sel_tens_q ? tens_q : ones_q;
    blank     = (refresh_q < RefW'(BLANK_CYC));
`ifdef LEADING_ZERO_BLANK_EN
    tens_hidden = sel_tens_q && (tens_q == 4'd0);
`else
    tens_hidden = 1'b0;
`endif
    active   = !blank && !tens_hidden;
    seg_d    = active ? enc_seg : SEG_OFF;
    ones_n_d = !(active && !sel_tens_q);
    tens_n_d = !(active && sel_tens_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      refresh_q   <= '0;
      sel_tens_q  <= 1'b0;
      seg_q       <= SEG_OFF;
      ones_n_q    <= 1'b1;
      tens_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      refresh_q   <= refresh_d;
      sel_tens_q  <= sel_tens_d;
      seg_q       <= seg_d;
      ones_n_q    <= ones_n_d;
      tens_n_q    <= tens_n_d;
    end
  end

  assign busy                = (state_q != StIdle);
  assign {A, B, C, D, E, F, G} = seg_q;
  assign dig_ones_n          = ones_n_q;
  assign dig_tens_n          = tens_n_q;

endmodule

// File: tb/tb_temp_display_scanner.sv
// Directed self-checking bench for temp_display_scanner (REFRESH_DIV = 8, BLANK_CYC = 2).
module tb_temp_display_scanner;

  localparam int unsigned RefDiv = 8;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S6 = 7'b0100000, S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100, SOff = 7'b1111111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] temp_in = '0;
  logic       temp_valid = 1'b0;
  logic       busy, A, B, C, D, E, F, G, dig_ones_n, dig_tens_n;
  logic [6:0] seg;

  int n_total = 0;
  int n_pass  = 0;

  assign seg = {A, B, C, D, E, F, G};

  always #5 clock = ~clock;

  temp_display_scanner #(
    .DATA_W      (8),
    .REFRESH_DIV (RefDiv),
    .BLANK_CYC   (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .busy       (busy),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .E          (E),
    .F          (F),
    .G          (G),
    .dig_ones_n (dig_ones_n),
    .dig_tens_n (dig_tens_n)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Observes one full scan period and records the first pattern seen in each digit slot.
  task automatic capture_slots(output logic [6:0] ts, output logic [6:0] os, output bit tseen);
    bit oseen;
    ts = 'x;
    os = 'x;
    tseen = 1'b0;
    oseen = 1'b0;
    for (int i = 0; i < 2 * RefDiv + 4; i++) begin
      tick();
      if (!dig_ones_n && !oseen) begin os = seg; oseen = 1'b1; end
      if (!dig_tens_n && !tseen) begin ts = seg; tseen = 1'b1; end
    end
  endtask

  task automatic test_reset();
    logic exp_on, exp_tn;
    logic [6:0] exp_seg;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
    else n_pass++;
    for (int n = 0; n <= 16; n++) begin
      exp_on  = !(n >= 3 && n <= 8);
      exp_tn  = !(n >= 11 && n <= 16 && !Lzb);
      exp_seg = (!exp_on || !exp_tn) ? S0 : SOff;
      n_total++;
      if ({dig_ones_n, dig_tens_n, seg} !== {exp_on, exp_tn, exp_seg})
        $display("FAIL reset_scan cyc=%0d got=%b%b_%b want=%b%b_%b", n, dig_ones_n,
                 dig_tens_n, seg, exp_on, exp_tn, exp_seg);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_single();
    logic [6:0] ts, os;
    bit tseen;
    temp_in = 8'd23;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      n_total++;
      if (busy !== 1'b1) $display("FAIL single_busy cyc=%0d got=%b want=1", c, busy);
      else n_pass++;
      tick();
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL single_idle got=%b want=0", busy);
    else n_pass++;
    capture_slots(ts, os, tseen);
    n_total++;
    if ({tseen, ts, os} !== {1'b1, S2, S3})
      $display("FAIL single_disp got=%b_%b_%b want=1_%b_%b", tseen, ts, os, S2, S3);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] ts, os;
    bit tseen;
    temp_in = 8'd25;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      n_total++;
      if (busy !== 1'b1) $display("FAIL b2b_busy cyc=%0d got=%b want=1", c, busy);
      else n_pass++;
      if (c == 3) begin temp_in = 8'd26; temp_valid = 1'b1; end
      tick();
      temp_valid = 1'b0;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL b2b_idle got=%b want=0", busy);
    else n_pass++;
    capture_slots(ts, os, tseen);
    n_total++;
    if ({tseen, ts, os} !== {1'b1, S2, S6})
      $display("FAIL b2b_disp got=%b_%b_%b want=1_%b_%b", tseen, ts, os, S2, S6);
    else n_pass++;
  endtask

  task automatic test_latest_wins();
    logic [6:0] ts, os;
    bit tseen;
    temp_in = 8'd40;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 2) begin temp_in = 8'd24; temp_valid = 1'b1; end
      if (c == 4) begin temp_in = 8'd31; temp_valid = 1'b1; end
      if (c == 6) begin temp_in = 8'd17; temp_valid = 1'b1; end
      tick();
      temp_valid = 1'b0;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL latest_idle got=%b want=0", busy);
    else n_pass++;
    capture_slots(ts, os, tseen);
    n_total++;
    if ({tseen, ts, os} !== {1'b1, S1, S7})
      $display("FAIL latest_disp got=%b_%b_%b want=1_%b_%b", tseen, ts, os, S1, S7);
    else n_pass++;
  endtask

  task automatic test_leading_zero();
    logic [6:0] ts, os;
    bit tseen;
    temp_in = 8'd7;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    for (int c = 1; c <= 9; c++) tick();
    capture_slots(ts, os, tseen);
    n_total++;
    if (os !== S7) $display("FAIL lzb_ones got=%b want=%b", os, S7);
    else n_pass++;
    n_total++;
    if (tseen !== !Lzb) $display("FAIL lzb_tens_seen got=%b want=%b", tseen, !Lzb);
    else n_pass++;
    n_total++;
    if (ts !== (Lzb ? 7'bx : S0)) $display("FAIL lzb_tens got=%b want=%b", ts, S0);
    else n_pass++;
  endtask

  task automatic test_clamp();
    logic [6:0] ts, os;
    bit tseen;
    temp_in = 8'd150;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    for (int c = 1; c <= 9; c++) tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL clamp_idle got=%b want=0", busy);
    else n_pass++;
    capture_slots(ts, os, tseen);
    n_total++;
    if ({tseen, ts, os} !== {1'b1, S9, S9})
      $display("FAIL clamp_disp got=%b_%b_%b want=1_%b_%b", tseen, ts, os, S9, S9);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [6:0] ts, os;
    bit tseen, busy_seen;
    temp_in = 8'd88;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin temp_in = 8'd55; temp_valid = 1'b1; end
      tick();
      temp_valid = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy);
    else n_pass++;
    busy_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy !== 1'b0) busy_seen = 1'b1;
      tick();
    end
    n_total++;
    if (busy_seen !== 1'b0) $display("FAIL rstmid_no_reload got=%b want=0", busy_seen);
    else n_pass++;
    capture_slots(ts, os, tseen);
    n_total++;
    if (os !== S0) $display("FAIL rstmid_ones got=%b want=%b", os, S0);
    else n_pass++;
    n_total++;
    if (tseen !== !Lzb) $display("FAIL rstmid_tens_seen got=%b want=%b", tseen, !Lzb);
    else n_pass++;
    n_total++;
    if (ts !== (Lzb ? 7'bx : S0)) $display("FAIL rstmid_tens got=%b want=%b", ts, S0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_latest_wins();
    test_leading_zero();
    test_clamp();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
